// File: rtl/key_filter_pkg.sv
// Shared types and default timing constants for the multi-channel key conditioner.
// The defaults assume a 12 MHz clock.
package key_filter_pkg;

    typedef enum logic [1:0] {
        REL  = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    localparam int DEF_DEB_CYC  = 240000;    // 20 ms
    localparam int DEF_LONG_CYC = 12000000;  // 1 s
    localparam int DEF_REP_CYC  = 2400000;   // 200 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-FF synchroniser, consecutive-stability debounce and a
// REL/HELD/LONG hold FSM producing long-press and auto-repeat strobes.
module key_filter_chan
    import key_filter_pkg::*;
#(
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int REP_EN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W  = $clog2(DEB_CYC);
    localparam int HOLD_W = $clog2(max_int(LONG_CYC, REP_CYC));
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYC - 1);

    logic              s1_reg;
    logic              s2_reg;
    logic              stable_reg;
    logic [DEB_W-1:0]  deb_cnt_reg;
    logic              key_state_reg;
    logic              press_pulse_reg;
    logic              release_pulse_reg;
    logic              long_pulse_reg;
    logic              repeat_pulse_reg;
    hold_state_t       state_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;

    logic deb_done;
    logic press_acc;
    logic rel_acc;

    // Raw level is active-low: stable=1 means released.
    assign deb_done  = (s2_reg != stable_reg) && (deb_cnt_reg == DEB_LAST);
    assign press_acc = deb_done && !s2_reg;
    assign rel_acc   = deb_done && s2_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg            <= 1'b1;
            s2_reg            <= 1'b1;
            stable_reg        <= 1'b1;
            deb_cnt_reg       <= '0;
            key_state_reg     <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            s1_reg <= key;
            s2_reg <= s1_reg;
            if (s2_reg == stable_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_done) begin
                stable_reg  <= s2_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
            press_pulse_reg   <= press_acc;
            release_pulse_reg <= rel_acc;
            key_state_reg     <= deb_done ? !s2_reg : key_state_reg;
        end
    end

    // Release is checked first so it pre-empts a coincident long/repeat terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= REL;
            hold_cnt_reg     <= '0;
            long_pulse_reg   <= 1'b0;
            repeat_pulse_reg <= 1'b0;
        end else begin
            long_pulse_reg   <= 1'b0;
            repeat_pulse_reg <= 1'b0;
            case (state_reg)
                REL: begin
                    hold_cnt_reg <= '0;
                    if (press_acc) begin
                        state_reg <= HELD;
                    end
                end
                HELD: begin
                    if (rel_acc) begin
                        state_reg    <= REL;
                        hold_cnt_reg <= '0;
                    end else if (hold_cnt_reg == LONG_LAST) begin
                        state_reg      <= LONG;
                        hold_cnt_reg   <= '0;
                        long_pulse_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                LONG: begin
                    if (rel_acc) begin
                        state_reg    <= REL;
                        hold_cnt_reg <= '0;
                    end else if (REP_EN == 0) begin
                        hold_cnt_reg <= '0;
                    end else if (hold_cnt_reg == REP_LAST) begin
                        hold_cnt_reg     <= '0;
                        repeat_pulse_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg    <= REL;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign key_state     = key_state_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign long_pulse    = long_pulse_reg;
    assign repeat_pulse  = repeat_pulse_reg;

endmodule

// File: rtl/key_filter_multi.sv
// N independent active-low push-button conditioners; each output bus bit
// belongs to the key channel with the same index.
module key_filter_multi
    import key_filter_pkg::*;
#(
    parameter int N        = 4,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int LONG_CYC = DEF_LONG_CYC,
    parameter int REP_CYC  = DEF_REP_CYC,
    parameter int REP_EN   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_state,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] repeat_pulse
);

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        key_filter_chan #(
            .DEB_CYC (DEB_CYC),
            .LONG_CYC(LONG_CYC),
            .REP_CYC (REP_CYC),
            .REP_EN  (REP_EN)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .key          (key[gi]),
            .key_state    (key_state[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi]),
            .long_pulse   (long_pulse[gi]),
            .repeat_pulse (repeat_pulse[gi])
        );
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi with short timing (DEB=8, LONG=64, REP=16);
// a second instance runs with auto-repeat disabled.
module tb_key_filter_multi;

    logic       clk;
    logic       rst;
    logic [1:0] key;
    logic [1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic [1:0] key_nr;
    logic [1:0] key_state_nr, press_pulse_nr, release_pulse_nr, long_pulse_nr, repeat_pulse_nr;

    key_filter_multi #(.N(2), .DEB_CYC(8), .LONG_CYC(64), .REP_CYC(16), .REP_EN(1)) dut (
        .clk(clk), .rst(rst), .key(key),
        .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
    );

    key_filter_multi #(.N(2), .DEB_CYC(8), .LONG_CYC(64), .REP_CYC(16), .REP_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .key(key_nr),
        .key_state(key_state_nr), .press_pulse(press_pulse_nr), .release_pulse(release_pulse_nr),
        .long_pulse(long_pulse_nr), .repeat_pulse(repeat_pulse_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pp_cnt[2], rl_cnt[2], lp_cnt[2], rep_cnt[2], lp_last[2], rep_last[2];
    int lp_nr_cnt, rep_nr_cnt, lp_nr_last;
    int p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            pp_cnt[i] = 0; rl_cnt[i] = 0; lp_cnt[i] = 0; rep_cnt[i] = 0;
            lp_last[i] = -1; rep_last[i] = -1;
        end
        lp_nr_cnt = 0; rep_nr_cnt = 0; lp_nr_last = -1;
    endtask

    // One clock; outputs are sampled on the falling edge, away from the active edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                pp_cnt[i]  += int'(press_pulse[i]);
                rl_cnt[i]  += int'(release_pulse[i]);
                lp_cnt[i]  += int'(long_pulse[i]);
                rep_cnt[i] += int'(repeat_pulse[i]);
                if (long_pulse[i])   lp_last[i]  = cyc;
                if (repeat_pulse[i]) rep_last[i] = cyc;
            end
            lp_nr_cnt  += int'(long_pulse_nr[0]);
            rep_nr_cnt += int'(repeat_pulse_nr[0]);
            if (long_pulse_nr[0]) lp_nr_last = cyc;
        end
    endtask

    initial begin
        rst = 1'b0; key = 2'b11; key_nr = 2'b11;
        clr();
        tick(3);
        chk("reset_outputs", 32'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        rst = 1'b1;
        tick(3);
        chk("idle_outputs", 32'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);

        // 1: bouncing input, then a clean press
        clr();
        for (p = 0; p < 10; p++) begin
            key[0] = (p % 2 == 1);
            tick(3);
        end
        chk("t1_bounce_no_press", 32'(pp_cnt[0]), 0);
        chk("t1_bounce_state", 32'(key_state[0]), 0);
        key[0] = 1'b0;
        tick(9);
        chk("t1_press_early", 32'(press_pulse[0]), 0);
        tick(1);
        chk("t1_press_at_10", 32'(press_pulse[0]), 1);
        tick(5);
        chk("t1_press_count", 32'(pp_cnt[0]), 1);
        chk("t1_key_state", 32'(key_state[0]), 1);
        key[0] = 1'b1;
        tick(10);
        chk("t1_release", 32'(release_pulse[0]), 1);
        tick(2);
        chk("t1_state_released", 32'(key_state[0]), 0);

        // 2: 7-cycle glitch rejected, 10-cycle pulse accepted
        clr();
        key[0] = 1'b0; tick(7);
        key[0] = 1'b1; tick(20);
        chk("t2_glitch_press", 32'(pp_cnt[0]), 0);
        chk("t2_glitch_state", 32'(key_state[0]), 0);
        key[0] = 1'b0; tick(10);
        chk("t2_pulse_press", 32'(press_pulse[0]), 1);
        key[0] = 1'b1; tick(9);
        chk("t2_release_early", 32'(release_pulse[0]), 0);
        tick(1);
        chk("t2_release_at_10", 32'(release_pulse[0]), 1);
        tick(4);

        // 3: long press with auto-repeat; release coincides with a repeat terminal count
        key[1] = 1'b0; tick(10);
        chk("t3_press", 32'(press_pulse[1]), 1);
        clr(); p = cyc;
        tick(63);
        chk("t3_long_early", 32'(long_pulse[1]), 0);
        tick(1);
        chk("t3_long_at_64", 32'(long_pulse[1]), 1);
        tick(86);
        chk("t3_long_count", 32'(lp_cnt[1]), 1);
        chk("t3_repeat_count", 32'(rep_cnt[1]), 5);
        chk("t3_repeat_last_144", 32'(rep_last[1] - p), 144);
        key[1] = 1'b1; tick(10);
        chk("t3_release", 32'(release_pulse[1]), 1);
        chk("t3_release_wins", 32'(repeat_pulse[1]), 0);
        tick(20);
        chk("t3_no_more_repeat", 32'(rep_cnt[1]), 5);
        chk("t3_release_count", 32'(rl_cnt[1]), 1);

        // 4: simultaneous press; releasing key 0 leaves key 1 timing intact
        key = 2'b00; tick(10);
        chk("t4_press_both", 32'(press_pulse), 32'(2'b11));
        clr(); p = cyc;
        tick(20);
        key[0] = 1'b1; tick(10);
        chk("t4_release_k0", 32'(release_pulse), 32'(2'b01));
        tick(33);
        chk("t4_long_early", 32'(long_pulse), 0);
        tick(1);
        chk("t4_long_k1", 32'(long_pulse), 32'(2'b10));
        tick(16);
        chk("t4_repeat_k1", 32'(repeat_pulse), 32'(2'b10));
        key[1] = 1'b1; tick(12);
        chk("t4_all_released", 32'(key_state), 0);

        // 5: reset while in LONG aborts silently
        key[0] = 1'b0; tick(10);
        chk("t5_press", 32'(press_pulse[0]), 1);
        clr();
        tick(64);
        chk("t5_long", 32'(long_pulse[0]), 1);
        tick(5);
        rst = 1'b0; #1;
        chk("t5_async_clear", 32'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        tick(3);
        rst = 1'b1;
        tick(9);
        chk("t5_no_release", 32'(rl_cnt[0]), 0);
        chk("t5_press_early", 32'(press_pulse[0]), 0);
        tick(1);
        chk("t5_press_after_rst", 32'(press_pulse[0]), 1);
        key[0] = 1'b1; tick(12);

        // 6: repeat disabled
        key_nr[0] = 1'b0; tick(10);
        chk("t6_press", 32'(press_pulse_nr[0]), 1);
        clr(); p = cyc;
        tick(200);
        chk("t6_long_count", 32'(lp_nr_cnt), 1);
        chk("t6_long_at_64", 32'(lp_nr_last - p), 64);
        chk("t6_no_repeat", 32'(rep_nr_cnt), 0);
        chk("t6_state_held", 32'(key_state_nr[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
